jtag_scan_master: RTL and testbench

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

---
 rtl/jtag_scan_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs DR/IR scans, TAP resets and idle clocks on a JTAG port.
// TCK is derived from clk_i by a half-period down-counter; all pins are registered.
module jtag_scan_master #(
    parameter int MaxLen     = 64,
    parameter int HalfPeriod = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [$clog2(MaxLen+1)-1:0] req_len_i,
    input  logic [MaxLen-1:0]           req_data_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [MaxLen-1:0]           rsp_data_o,
    output logic                        tck_o,
    output logic                        tms_o,
    output logic                        tdi_o,
    input  logic                        tdo_i
);
    // state        | meaning
    // ST_IDLE      | TAP parked in RunTestIdle, command accepted
    // ST_PREAMBLE  | walking RunTestIdle -> Shift-DR/IR, or the TAP-reset sequence
    // ST_SHIFT     | shift bits (scans) or idle clocks (TMS 0)
    // ST_POSTAMBLE | Exit1 -> Update -> RunTestIdle
    // ST_RESPOND   | response held until rsp_ready_i
    localparam int LenW = $clog2(MaxLen + 1);
    localparam int IdxW = (LenW > 3) ? LenW : 3;
    localparam int CntW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
    localparam logic [CntW-1:0] CntReload = CntW'(HalfPeriod - 1);
    localparam logic [1:0] OpDr = 2'd0, OpIr = 2'd1, OpRst = 2'd2, OpIdle = 2'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SHIFT, ST_POSTAMBLE, ST_RESPOND} state_t;

    state_t            r_state, w_state_nxt, w_step_state;
    logic [1:0]        r_op, w_op_nxt;
    logic              r_internal, w_internal_nxt;
    logic [IdxW-1:0]   r_len, w_len_nxt, r_idx, w_idx_nxt, w_step_idx, w_pre_last;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic [MaxLen-1:0] r_data, w_data_nxt, r_cap, w_cap_nxt, r_mask, w_mask_nxt;
    logic [MaxLen-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_tck, w_tck_nxt, r_tms, w_tms_nxt, r_tdi, w_tdi_nxt;
    logic              r_req_ready, w_req_ready_nxt, r_rsp_valid, w_rsp_valid_nxt;
    logic              w_scan, w_done;
    logic [LenW-1:0]   w_req_len;

    assign w_scan     = !r_op[1];
    assign w_req_len  = (req_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : req_len_i;
    assign w_pre_last = (r_op == OpDr) ? IdxW'(2) : (r_op == OpIr) ? IdxW'(3) : IdxW'(5);

    function automatic logic step_tms(input state_t st, input logic [IdxW-1:0] idx,
                                      input logic [1:0] op, input logic [IdxW-1:0] len);
        logic tms;
        tms = 1'b0;
        case (st)
            ST_PREAMBLE: begin
                case (op)
                    OpDr:    tms = (idx == '0);
                    OpIr:    tms = (idx < IdxW'(2));
                    default: tms = (idx < IdxW'(5));
                endcase
            end
            ST_SHIFT:     tms = (op != OpIdle) && ((idx + IdxW'(1)) == len);
            ST_POSTAMBLE: tms = (idx == '0);
            default:      tms = 1'b0;
        endcase
        return tms;
    endfunction

    // Which TCK cycle follows the current one, evaluated at the end of its high phase
    always_comb begin
        w_step_state = r_state;
        w_step_idx   = r_idx + IdxW'(1);
        w_done       = 1'b0;
        case (r_state)
            ST_PREAMBLE: begin
                if (r_idx == w_pre_last) begin
                    if (r_op == OpRst) begin
                        w_done = 1'b1;
                    end else begin
                        w_step_state = ST_SHIFT;
                        w_step_idx   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_step_idx == r_len) begin
                    if (r_op == OpIdle) begin
                        w_done = 1'b1;
                    end else begin
                        w_step_state = ST_POSTAMBLE;
                        w_step_idx   = '0;
                    end
                end
            end
            ST_POSTAMBLE: w_done = (r_idx != '0);
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_internal_nxt  = r_internal;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_cap_nxt       = r_cap;
        w_mask_nxt      = r_mask;
        w_rsp_data_nxt  = r_rsp_data;
        w_tck_nxt       = r_tck;
        w_tms_nxt       = r_tms;
        w_tdi_nxt       = r_tdi;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i && r_req_ready) begin
                    w_req_ready_nxt = 1'b0;
                    w_op_nxt        = req_op_i;
                    w_internal_nxt  = 1'b0;
                    w_len_nxt       = IdxW'(w_req_len);
                    w_idx_nxt       = '0;
                    w_cnt_nxt       = CntReload;
                    w_data_nxt      = req_data_i;
                    w_cap_nxt       = '0;
                    w_mask_nxt      = MaxLen'(1);
                    w_tck_nxt       = 1'b0;
                    w_tdi_nxt       = 1'b0;
                    if (w_req_len == '0 && req_op_i != OpRst) begin
                        w_state_nxt     = ST_RESPOND;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = '0;
                    end else if (req_op_i == OpIdle) begin
                        w_state_nxt = ST_SHIFT;
                        w_tms_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_PREAMBLE;
                        w_tms_nxt   = 1'b1;
                    end
                end
            end
            ST_PREAMBLE, ST_SHIFT, ST_POSTAMBLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else if (!r_tck) begin
                    w_tck_nxt = 1'b1;
                    w_cnt_nxt = CntReload;
                    // TDO is stable here: the target only moves it on the falling edge
                    if (r_state == ST_SHIFT && w_scan) begin
                        w_mask_nxt = r_mask << 1;
                        if (tdo_i) w_cap_nxt = r_cap | r_mask;
                    end
                end else begin
                    w_tck_nxt = 1'b0;
                    w_cnt_nxt = CntReload;
                    if (w_done) begin
                        w_tms_nxt = 1'b0;
                        w_tdi_nxt = 1'b0;
                        if (r_internal) begin
                            w_state_nxt     = ST_IDLE;
                            w_req_ready_nxt = 1'b1;
                            w_internal_nxt  = 1'b0;
                        end else begin
                            w_state_nxt     = ST_RESPOND;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = r_cap;
                        end
                    end else begin
                        w_state_nxt = w_step_state;
                        w_idx_nxt   = w_step_idx;
                        w_tms_nxt   = step_tms(w_step_state, w_step_idx, r_op, r_len);
                        if (w_step_state == ST_SHIFT && w_scan) begin
                            w_tdi_nxt  = r_data[0];
                            w_data_nxt = r_data >> 1;
                        end else begin
                            w_tdi_nxt = 1'b0;
                        end
                    end
                end
            end
            ST_RESPOND: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_data_nxt  = '0;
                    w_req_ready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset parks in an internal TAP-reset so the target is forced to RunTestIdle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_PREAMBLE;
            r_op        <= OpRst;
            r_internal  <= 1'b1;
            r_len       <= '0;
            r_idx       <= '0;
            r_cnt       <= CntReload;
            r_data      <= '0;
            r_cap       <= '0;
            r_mask      <= MaxLen'(1);
            r_rsp_data  <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_internal  <= w_internal_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_cap       <= w_cap_nxt;
            r_mask      <= w_mask_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_tck       <= w_tck_nxt;
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign tck_o       = r_tck;
    assign tms_o       = r_tms;
    assign tdi_o       = r_tdi;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a 1149.1 TAP target model (IDCODE 1, IR capture 00101)
// with a scoreboard of expected responses and latencies.
module tb_jtag_scan_master;
    localparam int MaxLen     = 64;
    localparam int HalfPeriod = 2;
    localparam int LenW       = $clog2(MaxLen + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [1:0]        req_op_i = 2'd0;
    logic [LenW-1:0]   req_len_i = '0;
    logic [MaxLen-1:0] req_data_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [MaxLen-1:0] rsp_data_o;
    logic              tck_o, tms_o, tdi_o;
    logic              tdo_i = 1'b0;

    jtag_scan_master #(.MaxLen(MaxLen), .HalfPeriod(HalfPeriod)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_len_i(req_len_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_spur = 0;
    bit expecting = 1'b0;
    bit tms_q[$];
    bit tdi_q[$];

    typedef struct {
        logic [63:0] data;
        int          lat;
    } sb_item_t;
    sb_item_t sb_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (rsp_valid_o && !expecting) n_spur <= n_spur + 1;
    always @(posedge tck_o) begin
        tms_q.push_back(tms_o);
        tdi_q.push_back(tdi_o);
    end

    // Target TAP model
    typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                              SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
    tap_t        tap_st = TLR;
    logic [4:0]  tap_ir = 5'b00001;
    logic [4:0]  tap_ir_sr = '0;
    logic [31:0] tap_dr_sr = '0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PA_DR;
            PA_DR:   return tms ? EX2_DR : PA_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PA_IR;
            PA_IR:   return tms ? EX2_IR : PA_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            UPD_IR:  return tms ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap_st)
            TLR:    tap_ir <= 5'b00001;
            CAP_IR: tap_ir_sr <= 5'b00101;
            SH_IR:  tap_ir_sr <= {tdi_o, tap_ir_sr[4:1]};
            UPD_IR: tap_ir <= tap_ir_sr;
            CAP_DR: tap_dr_sr <= (tap_ir == 5'b00001) ? 32'h1 : 32'h0;
            SH_DR:  tap_dr_sr <= (tap_ir == 5'b00001) ? {tdi_o, tap_dr_sr[31:1]} : {31'h0, tdi_o};
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o)
        tdo_i = (tap_st == SH_IR) ? tap_ir_sr[0] : (tap_st == SH_DR) ? tap_dr_sr[0] : 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] log_bits(input int base, input int n, input bit use_tdi);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n && i < 64; i++)
            if (base + i < tms_q.size()) v[i] = use_tdi ? tdi_q[base + i] : tms_q[base + i];
        return v;
    endfunction

    task automatic wait_ready(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (req_ready_o) ok = 1'b1;
            else @(negedge clk_i);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input int len,
                         input logic [63:0] data, input logic [63:0] exp_data,
                         input int ntck, input int hold, output int base);
        sb_item_t it;
        int acc;
        bit ok, stable;
        logic [63:0] held;
        base = tms_q.size();
        req_op_i = op;
        req_len_i = LenW'(len);
        req_data_i = data;
        req_valid_i = 1'b1;
        expecting = 1'b1;
        wait_ready(50, ok);
        check_val({tag, "_accept"}, 64'(ok), 64'd1);
        if (!ok) begin
            req_valid_i = 1'b0;
            expecting = 1'b0;
            return;
        end
        acc = cyc;
        it.data = exp_data;
        it.lat = 1 + 2 * HalfPeriod * ntck;
        sb_q.push_back(it);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (rsp_valid_o) ok = 1'b1;
            else @(negedge clk_i);
        end
        check_val({tag, "_rsp_seen"}, 64'(ok), 64'd1);
        if (!ok) begin
            sb_q.delete();
            expecting = 1'b0;
            return;
        end
        it = sb_q.pop_front();
        check_val({tag, "_lat"}, 64'(cyc - acc), 64'(it.lat));
        check_val({tag, "_data"}, rsp_data_o, it.data);
        check_val({tag, "_ntck"}, 64'(tms_q.size() - base), 64'(ntck));
        check_val({tag, "_tck_low"}, 64'(tck_o), 64'd0);
        if (hold > 0) begin
            held = rsp_data_o;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk_i);
                if (!rsp_valid_o || rsp_data_o !== held || req_ready_o || tck_o) stable = 1'b0;
            end
            check_val({tag, "_hold"}, 64'(stable), 64'd1);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check_val({tag, "_release"}, 64'({req_ready_o, rsp_valid_o}), 64'(2'b10));
        expecting = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c;
        bit ok;
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("rst_pins", 64'({tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o}), 64'(5'b01000));
        check_val("rst_rsp_data", rsp_data_o, 64'd0);

        // Automatic TAP reset after release
        base = tms_q.size();
        c = cyc;
        rst_ni = 1'b1;
        wait_ready(100, ok);
        check_val("boot_ready", 64'(ok), 64'd1);
        check_val("boot_cycles", 64'(cyc - c), 64'd24);
        check_val("boot_ntck", 64'(tms_q.size() - base), 64'd6);
        check_val("boot_tms", log_bits(base, 6, 1'b0), 64'h1F);
        check_val("boot_no_rsp", 64'(n_spur), 64'd0);

        do_op("ir5", 2'd1, 5, 64'h1, 64'h05, 11, 0, base);
        check_val("ir5_tms", log_bits(base, 11, 1'b0), 64'h303);
        check_val("ir5_tdi", log_bits(base, 11, 1'b1), 64'h010);

        do_op("dr32", 2'd0, 32, 64'h0, 64'h1, 37, 10, base);
        check_val("dr32_tms", log_bits(base, 37, 1'b0), 64'h0000_000C_0000_0001);
        check_val("dr32_tdi", log_bits(base, 37, 1'b1), 64'h0);

        do_op("dr0", 2'd0, 0, 64'hFFFF, 64'h0, 0, 0, base);

        do_op("idle3", 2'd3, 3, 64'hFF, 64'h0, 3, 0, base);
        check_val("idle3_tms", log_bits(base, 3, 1'b0), 64'h0);
        check_val("idle3_tdi", log_bits(base, 3, 1'b1), 64'h0);

        do_op("idle0", 2'd3, 0, 64'h0, 64'h0, 0, 0, base);

        do_op("taprst", 2'd2, 0, 64'h0, 64'h0, 6, 0, base);
        check_val("taprst_tms", log_bits(base, 6, 1'b0), 64'h1F);

        // Length 100 clamps to 64: 32 IDCODE bits, then the first 32 TDI bits come back
        do_op("clamp", 2'd0, 100, 64'hA5A5_0F0F_1234_5678, 64'h1234_5678_0000_0001, 69, 0, base);

        do_op("ir_byp", 2'd1, 5, 64'h1F, 64'h05, 11, 0, base);
        do_op("byp8", 2'd0, 8, 64'hB6, 64'h6C, 13, 0, base);

        // Reset in the middle of shift bit 10 of a 32-bit DR scan
        base = tms_q.size();
        req_op_i = 2'd0;
        req_len_i = LenW'(32);
        req_data_i = 64'h0;
        req_valid_i = 1'b1;
        wait_ready(50, ok);
        check_val("mid_accept", 64'(ok), 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tms_q.size() - base >= 14) ok = 1'b1;
            else @(negedge clk_i);
        end
        check_val("mid_reach", 64'(ok), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_pins", 64'({tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o}), 64'(5'b01000));
        repeat (3) @(negedge clk_i);
        check_val("mid_no_tck", 64'(tms_q.size() - base), 64'd14);
        base = tms_q.size();
        c = cyc;
        rst_ni = 1'b1;
        wait_ready(100, ok);
        check_val("mid_ready", 64'(ok), 64'd1);
        check_val("mid_boot_cycles", 64'(cyc - c), 64'd24);
        check_val("mid_boot_tms", log_bits(base, 6, 1'b0), 64'h1F);
        check_val("mid_boot_ntck", 64'(tms_q.size() - base), 64'd6);
        check_val("mid_no_rsp", 64'(n_spur), 64'd0);

        do_op("dr32b", 2'd0, 32, 64'h0, 64'h1, 37, 0, base);
        check_val("final_no_spur", 64'(n_spur), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
